// File: rtl/door_access_sequencer.sv
// Door LED-bar sequencer: arbitrates outside/inside open requests round-robin and runs
// one open/hold/close animation per grant while tracking room occupancy.
module door_access_sequencer #(
    parameter int STEP_CYCLES = 5_000_000,
    parameter int HOLD_STEPS  = 20,
    parameter int N_LEDS      = 10
) (
    input  logic              clk,
    input  logic              rst_a_p,
    input  logic              req_out,
    input  logic              req_in,
    input  logic              obstruct,
    output logic [N_LEDS-1:0] leds,
    output logic              person_in,
    output logic              grant_out,
    output logic              grant_in,
    output logic              busy,
    output logic [1:0]        state
);

    localparam int PW = $clog2(N_LEDS + 1);
    localparam int SW = $clog2(STEP_CYCLES);
    localparam int HW = $clog2(HOLD_STEPS + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_OPENING = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;
    localparam logic [1:0] S_CLOSING = 2'd3;

    localparam logic [PW-1:0] POS_MAX   = PW'(N_LEDS);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);

    logic [1:0]    state_q,     state_d;
    logic [PW-1:0] pos_q,       pos_d;
    logic [SW-1:0] step_q,      step_d;
    logic [HW-1:0] hold_q,      hold_d;
    logic          pend_out_q,  pend_out_d;
    logic          pend_in_q,   pend_in_d;
    logic          last_in_q,   last_in_d;
    logic          req_out_q,   req_out_d;
    logic          req_in_q,    req_in_d;
    logic          grant_out_q, grant_out_d;
    logic          grant_in_q,  grant_in_d;
    logic          person_in_q, person_in_d;

    logic edge_out_s, edge_in_s, own_edge_s, tick_s;

    // Next-state logic: edge capture, arbitration, step/hold timing and door position
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        hold_d      = hold_q;
        last_in_d   = last_in_q;
        grant_out_d = grant_out_q;
        grant_in_d  = grant_in_q;
        person_in_d = person_in_q;
        req_out_d   = req_out;
        req_in_d    = req_in;

        edge_out_s = req_out & ~req_out_q;
        edge_in_s  = req_in & ~req_in_q;
        own_edge_s = (edge_out_s & grant_out_q) | (edge_in_s & grant_in_q);
        tick_s     = (state_q != S_IDLE) && (step_q == STEP_LAST);

        // An edge from the side already being served never queues a second cycle
        pend_out_d = pend_out_q | (edge_out_s & ~grant_out_q);
        pend_in_d  = pend_in_q  | (edge_in_s  & ~grant_in_q);

        if (tick_s || (state_q == S_IDLE)) begin
            step_d = '0;
        end else begin
            step_d = step_q + SW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (pend_out_q && (!pend_in_q || last_in_q)) begin
                    state_d     = S_OPENING;
                    grant_out_d = 1'b1;
                    pend_out_d  = 1'b0;
                    last_in_d   = 1'b0;
                end else if (pend_in_q) begin
                    state_d    = S_OPENING;
                    grant_in_d = 1'b1;
                    pend_in_d  = 1'b0;
                    last_in_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OPENING: begin
                // A reopen from a fully open door goes straight back to HOLD
                if (pos_q == POS_MAX) begin
                    state_d = S_HOLD;
                    hold_d  = '0;
                end else if (tick_s) begin
                    pos_d = pos_q + PW'(1);
                    if (pos_q + PW'(1) == POS_MAX) begin
                        state_d = S_HOLD;
                        hold_d  = '0;
                    end else begin
                        state_d = S_OPENING;
                    end
                end else begin
                    state_d = S_OPENING;
                end
            end
            S_HOLD: begin
                // Blocking or re-pressing restarts a full hold period
                if (obstruct || own_edge_s) begin
                    hold_d = '0;
                    step_d = '0;
                end else if (tick_s) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = S_CLOSING;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end else begin
                    hold_d = hold_q;
                end
            end
            S_CLOSING: begin
                if (obstruct) begin
                    state_d = S_OPENING;
                end else if (tick_s) begin
                    pos_d = pos_q - PW'(1);
                    if (pos_q == PW'(1)) begin
                        state_d     = S_IDLE;
                        person_in_d = grant_out_q;
                        grant_out_d = 1'b0;
                        grant_in_d  = 1'b0;
                    end else begin
                        state_d = S_CLOSING;
                    end
                end else begin
                    state_d = S_CLOSING;
                end
            end
            default: begin
                state_d     = S_IDLE;
                pos_d       = '0;
                grant_out_d = 1'b0;
                grant_in_d  = 1'b0;
            end
        endcase

        if (state_d != state_q) begin
            step_d = '0;
        end else begin
            step_d = step_d;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            state_q     <= S_IDLE;
            pos_q       <= '0;
            step_q      <= '0;
            hold_q      <= '0;
            pend_out_q  <= 1'b0;
            pend_in_q   <= 1'b0;
            last_in_q   <= 1'b1;
            req_out_q   <= 1'b0;
            req_in_q    <= 1'b0;
            grant_out_q <= 1'b0;
            grant_in_q  <= 1'b0;
            person_in_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            step_q      <= step_d;
            hold_q      <= hold_d;
            pend_out_q  <= pend_out_d;
            pend_in_q   <= pend_in_d;
            last_in_q   <= last_in_d;
            req_out_q   <= req_out_d;
            req_in_q    <= req_in_d;
            grant_out_q <= grant_out_d;
            grant_in_q  <= grant_in_d;
            person_in_q <= person_in_d;
        end
    end

    // Thermometer decode of the registered door position
    always_comb begin
        for (int i = 0; i < N_LEDS; i++) begin
            leds[i] = (i < int'(pos_q));
        end
    end

    assign person_in = person_in_q;
    assign grant_out = grant_out_q;
    assign grant_in  = grant_in_q;
    assign busy      = (state_q != S_IDLE);
    assign state     = state_q;

endmodule

// File: tb/tb_door_access_sequencer.sv
// Directed self-checking bench for door_access_sequencer (STEP=4, HOLD=3, N_LEDS=10).
module tb_door_access_sequencer;

    localparam int STEP = 4;
    localparam int HOLD = 3;
    localparam int N    = 10;

    logic         clk = 1'b0;
    logic         rst_a_p = 1'b1;
    logic         req_out = 1'b0;
    logic         req_in = 1'b0;
    logic         obstruct = 1'b0;
    logic [N-1:0] leds;
    logic         person_in, grant_out, grant_in, busy;
    logic [1:0]   state;

    int checks = 0;
    int failures = 0;
    int ecnt = 0;

    always #5 clk = ~clk;

    door_access_sequencer #(
        .STEP_CYCLES(STEP),
        .HOLD_STEPS (HOLD),
        .N_LEDS     (N)
    ) dut (
        .clk      (clk),
        .rst_a_p  (rst_a_p),
        .req_out  (req_out),
        .req_in   (req_in),
        .obstruct (obstruct),
        .leds     (leds),
        .person_in(person_in),
        .grant_out(grant_out),
        .grant_in (grant_in),
        .busy     (busy),
        .state    (state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the e-th rising edge of the current sequence
    task automatic at_edge(input int e);
        while (ecnt < e) begin
            @(posedge clk);
            #1;
            ecnt++;
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (state !== 2'd0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, 32'(state), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_leds", 32'(leds), 32'd0);
        chk("rst_outs", {28'd0, person_in, grant_out, grant_in, busy}, 32'd0);
        rst_a_p = 1'b0;

        // Lone outside request: full cycle timing
        ecnt = 0; req_out = 1'b1;
        at_edge(1); chk("s2_still_idle", 32'(state), 32'd0); req_out = 1'b0;
        at_edge(2);
        chk("s2_opening", 32'(state), 32'd1);
        chk("s2_grants", {30'd0, grant_out, grant_in}, 32'h2);
        chk("s2_busy", 32'(busy), 32'd1);
        at_edge(5);  chk("s2_leds_e5", 32'(leds), 32'h000);
        at_edge(6);  chk("s2_leds_e6", 32'(leds), 32'h001);
        at_edge(41); chk("s2_leds_e41", 32'(leds), 32'h1FF);
        at_edge(42); chk("s2_leds_full", 32'(leds), 32'h3FF); chk("s2_hold", 32'(state), 32'd2);
        at_edge(53); chk("s2_hold_e53", 32'(state), 32'd2);
        at_edge(54); chk("s2_closing", 32'(state), 32'd3);
        at_edge(58); chk("s2_leds_e58", 32'(leds), 32'h1FF);
        at_edge(93); chk("s2_leds_e93", 32'(leds), 32'h001); chk("s2_state_e93", 32'(state), 32'd3);
        at_edge(94);
        chk("s2_idle", 32'(state), 32'd0);
        chk("s2_leds_empty", 32'(leds), 32'h000);
        chk("s2_outs", {28'd0, person_in, grant_out, grant_in, busy}, 32'h8);

        // Tie after an outside grant: round robin serves inside first
        ecnt = 0; req_out = 1'b1; req_in = 1'b1;
        at_edge(1); req_out = 1'b0; req_in = 1'b0;
        at_edge(2);  chk("rr_in_first", {30'd0, grant_out, grant_in}, 32'h1);
        at_edge(94); chk("rr_idle1", 32'(state), 32'd0); chk("rr_person_out", 32'(person_in), 32'd0);
        at_edge(95); chk("rr_out_next", {30'd0, grant_out, grant_in}, 32'h2); chk("rr_open2", 32'(state), 32'd1);
        at_edge(187); chk("rr_idle2", 32'(state), 32'd0); chk("rr_person_in", 32'(person_in), 32'd1);

        // Asynchronous reset in the middle of OPENING
        ecnt = 0; req_out = 1'b1;
        at_edge(1); req_out = 1'b0;
        at_edge(22); chk("s1_leds_pre", 32'(leds), 32'h01F); chk("s1_state_pre", 32'(state), 32'd1);
        rst_a_p = 1'b1;
        #1;
        chk("s1_leds_rst", 32'(leds), 32'h000);
        chk("s1_state_rst", 32'(state), 32'd0);
        chk("s1_outs_rst", {28'd0, person_in, grant_out, grant_in, busy}, 32'h0);
        @(posedge clk);
        #1;
        rst_a_p = 1'b0;
        ecnt = 0;
        at_edge(5); chk("s1_no_kept_req", 32'(state), 32'd0);

        // Tie right after reset: outside first, inside next
        ecnt = 0; req_out = 1'b1; req_in = 1'b1;
        at_edge(1); req_out = 1'b0; req_in = 1'b0;
        at_edge(2);  chk("s3_out_first", {30'd0, grant_out, grant_in}, 32'h2);
        at_edge(94); chk("s3_idle1", 32'(state), 32'd0); chk("s3_person1", 32'(person_in), 32'd1);
        at_edge(95); chk("s3_in_next", {30'd0, grant_out, grant_in}, 32'h1);
        at_edge(187); chk("s3_idle2", 32'(state), 32'd0); chk("s3_person2", 32'(person_in), 32'd0);

        // Obstruction pulse while closing at pos=4
        ecnt = 0; req_out = 1'b1;
        at_edge(1); req_out = 1'b0;
        at_edge(78); chk("s4_pos4", 32'(leds), 32'h00F); chk("s4_closing", 32'(state), 32'd3);
        obstruct = 1'b1;
        at_edge(79); chk("s4_reopen", 32'(state), 32'd1); chk("s4_pos_kept", 32'(leds), 32'h00F);
        chk("s4_grant_kept", {30'd0, grant_out, grant_in}, 32'h2);
        obstruct = 1'b0;
        at_edge(83);  chk("s4_pos5", 32'(leds), 32'h01F);
        at_edge(102); chk("s4_pos9", 32'(leds), 32'h1FF); chk("s4_open_e102", 32'(state), 32'd1);
        at_edge(103); chk("s4_hold", 32'(state), 32'd2);
        at_edge(114); chk("s4_hold_e114", 32'(state), 32'd2);
        at_edge(115); chk("s4_close_e115", 32'(state), 32'd3);
        wait_idle("s4_to_idle", 60);

        // Obstruction held for 50 cycles in HOLD
        ecnt = 0; req_out = 1'b1;
        at_edge(1); req_out = 1'b0;
        at_edge(44); chk("s5_hold", 32'(state), 32'd2);
        obstruct = 1'b1;
        at_edge(70); chk("s5_blocked_mid", 32'(state), 32'd2); chk("s5_leds_mid", 32'(leds), 32'h3FF);
        at_edge(94); chk("s5_blocked_end", 32'(state), 32'd2); chk("s5_leds_end", 32'(leds), 32'h3FF);
        obstruct = 1'b0;
        at_edge(105); chk("s5_hold_e105", 32'(state), 32'd2);
        at_edge(106); chk("s5_close_e106", 32'(state), 32'd3);
        wait_idle("s5_to_idle", 60);

        // Inside request held high for 200 cycles: one cycle only
        ecnt = 0; req_in = 1'b1;
        at_edge(2);   chk("s6_grant_in", {30'd0, grant_out, grant_in}, 32'h1);
        at_edge(94);  chk("s6_idle", 32'(state), 32'd0); chk("s6_person", 32'(person_in), 32'd0);
        at_edge(150); chk("s6_no_retrig", 32'(state), 32'd0);
        at_edge(200); req_in = 1'b0;
        at_edge(203); chk("s6_quiet", 32'(busy), 32'd0);

        // Inside re-press during its own HOLD extends the hold
        ecnt = 0; req_in = 1'b1;
        at_edge(1); req_in = 1'b0;
        at_edge(47); chk("s6b_hold", 32'(state), 32'd2);
        req_in = 1'b1;
        at_edge(48); req_in = 1'b0;
        at_edge(54);  chk("s6b_extended", 32'(state), 32'd2);
        at_edge(59);  chk("s6b_hold_e59", 32'(state), 32'd2);
        at_edge(60);  chk("s6b_close_e60", 32'(state), 32'd3);
        at_edge(100); chk("s6b_idle", 32'(state), 32'd0);
        at_edge(106); chk("s6b_no_second", 32'(state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
